// File: rtl/ad9364_dac_src_sched.sv
// Transmit sample scheduler for the AD9364 DAC port: paces two valid/ready
// sources onto fixed sample slots with round-robin, packet-locking arbitration.
module ad9364_dac_src_sched #(
  parameter int unsigned DW        = 12,
  parameter int unsigned UFL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 dac_r1_mode,
  input  logic                 src0_valid,
  input  logic [4*DW-1:0]      src0_data,
  input  logic                 src0_last,
  output logic                 src0_ready,
  input  logic                 src1_valid,
  input  logic [4*DW-1:0]      src1_data,
  input  logic                 src1_last,
  output logic                 src1_ready,
  output logic                 dac_valid,
  output logic [DW-1:0]        dac_data_i1,
  output logic [DW-1:0]        dac_data_q1,
  output logic [DW-1:0]        dac_data_i2,
  output logic [DW-1:0]        dac_data_q2,
  output logic [1:0]           active_src,
  output logic                 underflow,
  output logic [UFL_CNT_W-1:0] underflow_cnt
);

  localparam int unsigned SW = 4 * DW;
  localparam int unsigned HW = 2 * DW;

  typedef enum logic [1:0] {
    OPEN  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic            mode_q;
  logic            rr_last;
  logic [SW-1:0]   data_q;

  logic            mode_chg;
  logic [1:0]      cnt_eff;
  logic [1:0]      cnt_top;
  logic [1:0]      cnt_nxt;
  logic            slot;
  logic            go;
  logic            sel0;
  logic            sel1;
  logic            take0;
  logic            take1;
  logic            ufl_c;
  logic [SW-1:0]   sample;

  // A mode change restarts pacing: that cycle counts as a slot
  assign mode_chg = dac_r1_mode != mode_q;
  assign cnt_eff  = mode_chg ? 2'd0 : cnt;
  assign cnt_top  = dac_r1_mode ? 2'd1 : 2'd3;
  assign cnt_nxt  = (cnt_eff >= cnt_top) ? 2'd0 : cnt_eff + 2'd1;
  assign slot     = cnt_eff == 2'd0;
  assign go       = rstn & enable & slot;

  // Candidate selection; rr_last=1 means src1 was served last, so src0 wins ties
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    unique case (state)
      OPEN: begin
        sel0 = src0_valid & (~src1_valid | rr_last);
        sel1 = src1_valid & ~sel0;
      end
      LOCK0:   sel0 = src0_valid;
      LOCK1:   sel1 = src1_valid;
      default: ;
    endcase
  end

  assign take0      = go & sel0;
  assign take1      = go & sel1;
  assign src0_ready = take0;
  assign src1_ready = take1;
  assign ufl_c      = go & (((state == LOCK0) & ~src0_valid) |
                            ((state == LOCK1) & ~src1_valid));

  always_comb begin
    sample = '0;
    if (take0)      sample = src0_data;
    else if (take1) sample = src1_data;
    if (dac_r1_mode) sample[SW-1:HW] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= OPEN;
      cnt           <= 2'd0;
      mode_q        <= dac_r1_mode;
      rr_last       <= 1'b1;
      dac_valid     <= 1'b0;
      data_q        <= '0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      mode_q    <= dac_r1_mode;
      cnt       <= cnt_nxt;
      dac_valid <= slot;
      underflow <= ufl_c;
      if (slot) data_q <= sample;
      if (ufl_c && (underflow_cnt != '1))
        underflow_cnt <= underflow_cnt + UFL_CNT_W'(1);
      if (!enable) begin
        state <= OPEN;
      end else if (take0) begin
        rr_last <= 1'b0;
        state   <= src0_last ? OPEN : LOCK0;
      end else if (take1) begin
        rr_last <= 1'b1;
        state   <= src1_last ? OPEN : LOCK1;
      end
    end
  end

  assign active_src  = state;
  assign dac_data_i1 = data_q[DW-1:0];
  assign dac_data_q1 = data_q[2*DW-1:DW];
  assign dac_data_i2 = data_q[3*DW-1:2*DW];
  assign dac_data_q2 = data_q[4*DW-1:3*DW];

endmodule

// File: tb/tb_ad9364_dac_src_sched.sv
// Randomized bench for ad9364_dac_src_sched against a queue-based slot model.
module tb_ad9364_dac_src_sched;

  localparam int unsigned DW  = 12;
  localparam int unsigned UW  = 4;
  localparam int unsigned SW  = 4 * DW;

  logic          clk = 1'b0;
  logic          rstn, enable, dac_r1_mode;
  logic          src0_valid, src0_last, src0_ready;
  logic          src1_valid, src1_last, src1_ready;
  logic [SW-1:0] src0_data, src1_data;
  logic          dac_valid;
  logic [DW-1:0] dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;
  logic [1:0]    active_src;
  logic          underflow;
  logic [UW-1:0] underflow_cnt;

  ad9364_dac_src_sched #(.DW(DW), .UFL_CNT_W(UW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .dac_r1_mode(dac_r1_mode),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_last(src0_last), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_last(src1_last), .src1_ready(src1_ready),
    .dac_valid(dac_valid), .dac_data_i1(dac_data_i1), .dac_data_q1(dac_data_q1),
    .dac_data_i2(dac_data_i2), .dac_data_q2(dac_data_q2),
    .active_src(active_src), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] data;
    bit            last;
  } item_t;

  item_t q0[$];
  item_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Model: slots occur every P cycles counted from the last reset or mode change
  int            m_since;
  bit            m_prev_mode;
  int            m_lock;   // 0 none, 1 src0, 2 src1
  int            m_pref;   // source that wins a tie
  bit            e_valid;
  logic [SW-1:0] e_data;
  bit            e_ufl;
  int            e_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input logic [SW-1:0] d, input bit l);
    item_t it;
    it.data = d;
    it.last = l;
    return it;
  endfunction

  // One clock: drive sources from queues, check ready, advance model, check outputs
  task automatic cycle();
    int p, eff, take;
    bit slot, ufl, tlast;
    logic [SW-1:0] tdata;
    src0_valid = q0.size() > 0;
    if (src0_valid) begin src0_data = q0[0].data; src0_last = q0[0].last; end
    src1_valid = q1.size() > 0;
    if (src1_valid) begin src1_data = q1[0].data; src1_last = q1[0].last; end
    #1;
    p    = dac_r1_mode ? 2 : 4;
    eff  = (dac_r1_mode != m_prev_mode) ? 0 : m_since;
    slot = (eff % p) == 0;
    take = -1;
    ufl  = 1'b0;
    if (rstn && enable && slot) begin
      if (m_lock == 0) begin
        if (src0_valid && (!src1_valid || m_pref == 0)) take = 0;
        else if (src1_valid) take = 1;
      end else if (m_lock == 1) begin
        if (src0_valid) take = 0; else ufl = 1'b1;
      end else begin
        if (src1_valid) take = 1; else ufl = 1'b1;
      end
    end
    if (src0_valid) chk("src0_ready", 64'(src0_ready), 64'(take == 0));
    if (src1_valid) chk("src1_ready", 64'(src1_ready), 64'(take == 1));
    chk("ready_both", 64'(src0_ready & src1_ready), 64'(0));

    if (!rstn) begin
      m_since = 0; m_lock = 0; m_pref = 0;
      e_valid = 0; e_data = '0; e_ufl = 0; e_cnt = 0;
    end else begin
      m_since = eff + 1;
      e_ufl   = ufl;
      if (ufl && e_cnt < 15) e_cnt++;
      e_valid = slot;
      if (!enable) m_lock = 0;
      if (take >= 0) begin
        if (take == 0) begin tdata = q0[0].data; tlast = q0[0].last; void'(q0.pop_front()); end
        else           begin tdata = q1[0].data; tlast = q1[0].last; void'(q1.pop_front()); end
        if (m_lock == 0) m_pref = 1 - take;
        m_lock = tlast ? 0 : take + 1;
      end
      if (slot) begin
        e_data = (take >= 0) ? tdata : '0;
        if (dac_r1_mode) e_data[SW-1:SW/2] = '0;
      end
    end
    m_prev_mode = dac_r1_mode;

    @(posedge clk);
    @(negedge clk);
    chk("dac_valid", 64'(dac_valid), 64'(e_valid));
    chk("dac_data", 64'({dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1}), 64'(e_data));
    chk("active_src", 64'(active_src), 64'(m_lock));
    chk("underflow", 64'(underflow), 64'(e_ufl));
    chk("underflow_cnt", 64'(underflow_cnt), 64'(e_cnt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Run until a source queue shrinks to target, bounded by maxc cycles
  task automatic run_until(input int which, input int target, input int maxc);
    int n = 0;
    while (((which == 0) ? q0.size() : q1.size()) > target && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain", 64'((which == 0) ? q0.size() : q1.size()), 64'(target));
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; dac_r1_mode = 1'b1;
    src0_valid = 0; src1_valid = 0; src0_last = 0; src1_last = 0;
    src0_data = '0; src1_data = '0;
    m_since = 0; m_prev_mode = 1'b1; m_lock = 0; m_pref = 0;
    e_valid = 0; e_data = '0; e_ufl = 0; e_cnt = 0;
    @(negedge clk);

    // Reset and pacing in both modes
    run(5);
    rstn = 1'b1;
    run(8);
    dac_r1_mode = 1'b0;
    run(12);

    // Single locked packet from src0
    q0.push_back(mk({12'h123, 12'h456, 12'h001, 12'h7FF}, 1'b0));
    q0.push_back(mk({12'h800, 12'hFFF, 12'h002, 12'h7FE}, 1'b0));
    q0.push_back(mk({12'h0AA, 12'h055, 12'h003, 12'h7FD}, 1'b1));
    run_until(0, 0, 40);
    run(2);
    chk("single_unlocked", 64'(active_src), 64'(0));

    // Round-robin with single-sample packets
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(48'($urandom()), 1'b1));
      q1.push_back(mk(48'($urandom()), 1'b1));
    end
    run_until(1, 0, 60);
    run_until(0, 0, 20);

    // Lock then underflow for two slots while src1 waits
    q0.push_back(mk(48'($urandom()), 1'b0));
    run_until(0, 0, 20);
    q1.push_back(mk(48'($urandom()), 1'b1));
    run(8);
    chk("ufl_cnt_two", 64'(underflow_cnt), 64'(2));
    q0.push_back(mk(48'($urandom()), 1'b0));
    q0.push_back(mk(48'($urandom()), 1'b0));
    q0.push_back(mk(48'($urandom()), 1'b1));
    run_until(0, 0, 40);
    run_until(1, 0, 20);

    // Counter saturation
    q0.push_back(mk(48'($urandom()), 1'b0));
    run_until(0, 0, 20);
    run(80);
    chk("ufl_cnt_sat", 64'(underflow_cnt), 64'(15));
    q0.push_back(mk(48'($urandom()), 1'b1));
    run_until(0, 0, 20);

    // Enable drop mid src1 packet
    for (int i = 0; i < 4; i++) q1.push_back(mk(48'($urandom()), i == 3));
    run_until(1, 3, 20);
    enable = 1'b0;
    run(8);
    chk("enable_unlock", 64'(active_src), 64'(0));
    enable = 1'b1;
    run_until(1, 0, 40);

    // Reset pulse mid src1 packet
    for (int i = 0; i < 3; i++) q1.push_back(mk(48'($urandom()), i == 2));
    run_until(1, 2, 20);
    rstn = 1'b0;
    run(2);
    chk("rst_outputs", 64'({dac_valid, active_src, underflow, underflow_cnt,
                           dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1}), 64'(0));
    rstn = 1'b1;
    run_until(1, 0, 40);

    // Mode toggle and enable fall together
    dac_r1_mode = 1'b1;
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(3);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) rstn = 1'b0; else rstn = 1'b1;
      if ($urandom_range(59) == 0) enable = ~enable;
      if ($urandom_range(79) == 0) dac_r1_mode = ~dac_r1_mode;
      if (q0.size() < 2 && $urandom_range(2) == 0)
        q0.push_back(mk(48'({$urandom(), $urandom()}), $urandom_range(2) == 0));
      if (q1.size() < 2 && $urandom_range(3) == 0)
        q1.push_back(mk(48'({$urandom(), $urandom()}), $urandom_range(2) == 0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
